// File: rtl/cmp_arbiter_pkg.sv
// cmp_arbiter_pkg: shared types and the round-robin pick helper for cmp_arbiter
package cmp_arbiter_pkg;
  localparam int CMP_MAX_REQ = 32;
  localparam int CMP_TAG_MAX_W = 16;
  typedef logic [31:0] word;
  typedef struct packed {
    logic mode;
    logic un;
    logic neg;
  } comparison_op_t;
  typedef struct packed {
    word a;
    word b;
    comparison_op_t op;
    logic [CMP_TAG_MAX_W-1:0] tag;
  } cmp_req_t;
  // First asserted bit of valid[n-1:0] scanning upward from ptr with wrap; one-hot or zero.
  function automatic logic [CMP_MAX_REQ-1:0] rr_pick(input logic [CMP_MAX_REQ-1:0] valid,
                                                     input int unsigned ptr, input int unsigned n);
    logic [CMP_MAX_REQ-1:0] g;
    int unsigned idx;
    g = '0;
    for (int unsigned k = 0; k < CMP_MAX_REQ; k++) begin
      if (k < n) begin
        idx = (ptr + k >= n) ? ptr + k - n : ptr + k;
        if (g == '0 && valid[idx]) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/cmp_arbiter_comparison_unit.sv
// comparison_unit: 1-bit compare of a/b under op {mode,un,neg}
// Ports: a, b operands; op selects eq (mode=0) or signed/unsigned lt (mode=1); neg inverts; result out.
module comparison_unit
  import cmp_arbiter_pkg::*;
(
  input  word            a,
  input  word            b,
  input  comparison_op_t op,
  output logic           result
);
  logic base;
  always_comb begin
    base = !op.mode ? (a == b) : op.un ? (a < b) : ($signed(a) < $signed(b));
    result = base ^ op.neg;
  end
endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one comparison_unit between N_REQ requesters through a single registered slot
// Ports: clk; reset (async, active-high); per requester req_valid/req_ready/req_a/req_b/req_op/req_tag
// and rsp_valid/rsp_ready; shared rsp_result/rsp_tag; busy while the slot holds a request.
// Build option: define CMP_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic           [N_REQ-1:0]            req_valid,
  output logic           [N_REQ-1:0]            req_ready,
  input  word            [N_REQ-1:0]            req_a,
  input  word            [N_REQ-1:0]            req_b,
  input  comparison_op_t [N_REQ-1:0]            req_op,
  input  logic           [N_REQ-1:0][TAG_W-1:0] req_tag,
  output logic           [N_REQ-1:0]            rsp_valid,
  input  logic           [N_REQ-1:0]            rsp_ready,
  output logic                            rsp_result,
  output logic           [TAG_W-1:0]            rsp_tag,
  output logic                            busy
);
  localparam int OW = $clog2(N_REQ);
  logic                   slot_valid;
  logic [OW-1:0]          owner;
  logic [OW-1:0]          win;
  cmp_req_t               slot;
  logic                   drain;
  logic                   can_accept;
  logic                   cmp_out;
  logic                   unused_bits;
  logic [CMP_MAX_REQ-1:0] pick;
  logic [N_REQ-1:0]       grant;
`ifdef CMP_ARB_FIXED_PRIO_EN
  assign pick = rr_pick(CMP_MAX_REQ'(req_valid), 0, N_REQ);
`else
  logic [OW-1:0] rr_ptr;
  assign pick = rr_pick(CMP_MAX_REQ'(req_valid), 32'(rr_ptr), N_REQ);
  always_ff @(posedge clk or posedge reset)
    if (reset) rr_ptr <= '0;
    else if (|grant) rr_ptr <= (32'(win) == N_REQ - 1) ? '0 : win + OW'(1);
`endif
  // A draining slot can be refilled in the same cycle, so there is no bubble at full rate.
  assign drain = slot_valid && rsp_ready[owner];
  assign can_accept = !slot_valid || drain;
  assign grant = (can_accept && !reset) ? pick[N_REQ-1:0] : '0;
  assign req_ready = grant;
  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++) win = grant[i] ? OW'(i) : win;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      slot_valid <= 1'b0;
      owner <= '0;
      slot <= '0;
    end else if (|grant) begin
      slot_valid <= 1'b1;
      owner <= win;
      slot <= '{a: req_a[win], b: req_b[win], op: req_op[win], tag: CMP_TAG_MAX_W'(req_tag[win])};
    end else if (drain) slot_valid <= 1'b0;
  comparison_unit u_cmp (
    .a     (slot.a),
    .b     (slot.b),
    .op    (slot.op),
    .result(cmp_out)
  );
  always_comb
    for (int i = 0; i < N_REQ; i++) rsp_valid[i] = slot_valid && owner == OW'(i);
  // Gated so the bus reads 0 when idle; the zeroed slot would otherwise compare equal.
  assign rsp_result = slot_valid & cmp_out;
  assign rsp_tag = slot.tag[TAG_W-1:0];
  assign busy = slot_valid;
  assign unused_bits = ^{pick[CMP_MAX_REQ-1:N_REQ], slot.tag[CMP_TAG_MAX_W-1:TAG_W]};
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed vectors plus a per-cycle reference model of the arbiter's rules
module tb_cmp_arbiter;
  import cmp_arbiter_pkg::*;
  localparam int N = 2;
  localparam int TW = 4;
  localparam logic [2:0] EQ = 3'b000, NE = 3'b001, SLT = 3'b100, ULT = 3'b110, UGE = 3'b111;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  word [N-1:0] req_a, req_b;
  comparison_op_t [N-1:0] req_op;
  logic [N-1:0][TW-1:0] req_tag;
  logic rsp_result;
  logic [TW-1:0] rsp_tag;
  logic busy;
  int vectors = 0;
  int errors = 0;

  cmp_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cmp_f(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    bit r;
    case (op[2:1])
      2'b10: r = $signed(a) < $signed(b);
      2'b11: r = a < b;
      default: r = a == b;
    endcase
    return r ^ op[0];
  endfunction

  // Reference model: one pending result at most; winner found by scanning requesters
  bit m_valid;
  int m_owner, m_ptr;
  logic [31:0] m_a, m_b;
  logic [2:0] m_op;
  logic [TW-1:0] m_tag;
  int grant_now;

  always_comb begin
    grant_now = -1;
    if (!reset && !(m_valid && !rsp_ready[m_owner]))
      for (int k = 0; k < N; k++) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
        if (grant_now < 0 && req_valid[k]) grant_now = k;
`else
        if (grant_now < 0 && req_valid[(m_ptr + k) % N]) grant_now = (m_ptr + k) % N;
`endif
      end
  end

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_valid <= 0;
      m_owner <= 0;
      m_ptr <= 0;
      m_a <= 0;
      m_b <= 0;
      m_op <= 0;
      m_tag <= 0;
    end else if (grant_now >= 0) begin
      m_valid <= 1;
      m_owner <= grant_now;
      m_ptr <= (grant_now + 1) % N;
      m_a <= req_a[grant_now];
      m_b <= req_b[grant_now];
      m_op <= req_op[grant_now];
      m_tag <= req_tag[grant_now];
    end else if (m_valid && rsp_ready[m_owner]) m_valid <= 0;

  always @(negedge clk) begin
    chk("req_ready", 64'(req_ready), grant_now < 0 ? 64'd0 : 64'd1 << grant_now);
    chk("rsp_valid", 64'(rsp_valid), m_valid ? 64'd1 << m_owner : 64'd0);
    chk("rsp_result", 64'(rsp_result), m_valid ? 64'(cmp_f(m_a, m_b, m_op)) : 64'd0);
    chk("rsp_tag", 64'(rsp_tag), 64'(m_tag));
    chk("busy", 64'(busy), 64'(m_valid));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, word a, word b, logic [2:0] op, logic [TW-1:0] tag);
    req_a[i] = a;
    req_b[i] = b;
    req_op[i] = comparison_op_t'(op);
    req_tag[i] = tag;
    req_valid[i] = 1'b1;
  endtask

  task automatic one(int i, word a, word b, logic [2:0] op, logic [TW-1:0] tag, bit exp);
    cyc();
    set_req(i, a, b, op, tag);
    rsp_ready = '1;
    @(negedge clk);
    chk("lone_grant", 64'(req_ready), 64'd1 << i);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("lone_result", 64'(rsp_result), 64'(exp));
    chk("lone_tag", 64'(rsp_tag), 64'(tag));
  endtask

  int eg, prev;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    req_tag = '0;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_result", 64'(rsp_result), 0);
    chk("reset_req_ready", 64'(req_ready), 0);
    cyc();
    reset = 1'b0;
    // single request held under backpressure
    cyc();
    set_req(0, 5, 7, SLT, 3);
    @(negedge clk);
    chk("t1_grant", 64'(req_ready), 1);
    cyc();
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t1_rsp_valid", 64'(rsp_valid), 1);
      chk("t1_result", 64'(rsp_result), 1);
      chk("t1_tag", 64'(rsp_tag), 3);
      cyc();
    end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = '0;
    @(negedge clk);
    chk("t1_drained", 64'(busy), 0);
    // signed vs unsigned and equality encodings
    one(0, 32'hFFFF_FFFF, 1, SLT, 1, 1);
    one(1, 32'hFFFF_FFFF, 1, ULT, 2, 0);
    one(0, 32'hFFFF_FFFF, 1, UGE, 4, 1);
    one(0, 9, 9, 3'b010, 5, 1);
    one(1, 9, 9, NE, 6, 0);
    // contention with both requesters, results drained every cycle
    cyc();
    set_req(0, 10, 20, SLT, 4'hA);
    set_req(1, 20, 10, SLT, 4'hB);
    rsp_ready = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef CMP_ARB_FIXED_PRIO_EN
      eg = 0;
`else
      eg = k % 2;
`endif
      chk("cont_grant", 64'(req_ready), 64'd1 << eg);
      if (k > 0) begin
        chk("cont_rsp_valid", 64'(rsp_valid), 64'd1 << prev);
        chk("cont_tag", 64'(rsp_tag), prev == 1 ? 64'hB : 64'hA);
        chk("cont_result", 64'(rsp_result), prev == 1 ? 64'd0 : 64'd1);
      end
      prev = eg;
      cyc();
    end
    req_valid = '0;
    @(negedge clk);
    chk("cont_last_valid", 64'(rsp_valid), 64'd1 << prev);
    // backpressure: req1 owns the slot, req0 waits
    cyc();
    set_req(1, 1, 2, ULT, 4'hB);
    rsp_ready = '0;
    @(negedge clk);
    chk("bp_grant1", 64'(req_ready), 2);
    cyc();
    set_req(0, 3, 3, EQ, 5);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_no_grant", 64'(req_ready), 0);
      chk("bp_rsp_valid", 64'(rsp_valid), 2);
      chk("bp_tag", 64'(rsp_tag), 64'hB);
      chk("bp_result", 64'(rsp_result), 1);
      if (k < 2) cyc();
    end
    cyc();
    rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_release_grant", 64'(req_ready), 1);
    cyc();
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    chk("bp_new_owner", 64'(rsp_valid), 1);
    chk("bp_new_tag", 64'(rsp_tag), 5);
    // reset while the slot holds a result
    cyc();
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = '0;
    set_req(0, 9, 9, EQ, 7);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("rst_pre_valid", 64'(rsp_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    cyc();
    reset = 1'b0;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("rst_after_busy", 64'(busy), 0);
    chk("rst_after_valid", 64'(rsp_valid), 0);
    // pointer restarts at 0: both valid -> 0 first
    cyc();
    set_req(0, 1, 1, EQ, 1);
    set_req(1, 1, 2, EQ, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
`ifdef CMP_ARB_FIXED_PRIO_EN
      chk("prio_grant", 64'(req_ready), 1);
`else
      chk("post_rst_grant", 64'(req_ready), k % 2 == 0 ? 64'd1 : 64'd2);
`endif
      cyc();
    end
    req_valid = '0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
